// File: rtl/sound_pkg.sv
// Shared definitions for the sound controller: playback FSM encoding and
// control-register bit positions.
package sound_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PEND  = 2'd2,
        ST_ISSUE = 2'd3
    } state_t;

    localparam int CTRL_PLAY  = 0;
    localparam int CTRL_FLUSH = 1;
    localparam int CTRL_CLR   = 2;

endpackage

// File: rtl/sound_fifo.sv
// Byte-wide sample FIFO with registered level/full/empty and a one-cycle flush.
// A push that meets a full FIFO is reported on push_drop unless a pop frees a slot.
module sound_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [7:0]         wr_data,
    output logic [7:0]         rd_data,
    output logic [FIFO_AW:0]   level,
    output logic [FIFO_AW:0]   level_next,
    output logic               full,
    output logic               empty,
    output logic               push_drop
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_LVL = {1'b1, {FIFO_AW{1'b0}}};

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               do_push, do_pop;

    always_comb begin
        do_pop    = pop & ~empty_q & ~flush;
        do_push   = push & (~full_q | do_pop) & ~flush;
        push_drop = push & full_q & ~do_pop & ~flush;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      level_d = level_q + 1'b1;
            else if (do_pop && !do_push) level_d = level_q - 1'b1;
        end
        full_d  = (level_d == DEPTH_LVL);
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data    = mem[rd_ptr_q];
    assign level      = level_q;
    assign level_next = level_d;
    assign full       = full_q;
    assign empty      = empty_q;

endmodule

// File: rtl/sound_ctrl.sv
// Sound controller: arbitrates CPU beeper/covox writes against timed FIFO
// playback and forwards one registered strobe per cycle to the sound datapath.
module sound_ctrl
    import sound_pkg::*;
#(
    parameter int FIFO_AW = 4,
    parameter int DIV_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       din,
    input  logic             cpu_beep_wr,
    input  logic             cpu_covox_wr,
    input  logic             fifo_wr,
    input  logic             rate_wr_lo,
    input  logic             rate_wr_hi,
    input  logic             ctrl_wr,
    output logic [7:0]       snd_din,
    output logic             snd_beeper_wr,
    output logic             snd_covox_wr,
    output logic [FIFO_AW:0] fifo_level,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             underrun,
    output logic             overflow,
    output logic             half_irq
);

    localparam logic [FIFO_AW:0] HALF_LVL = {2'b01, {(FIFO_AW-1){1'b0}}};
    localparam logic [DIV_W-1:0] ONE      = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic               play_q, play_d;
    logic [DIV_W-1:0]   rate_q, rate_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   reload_eff;
    logic               hold_valid_q, hold_valid_d;
    logic [7:0]         hold_data_q, hold_data_d;
    logic [7:0]         snd_din_q, snd_din_d;
    logic               snd_beeper_wr_q, snd_beeper_wr_d;
    logic               snd_covox_wr_q, snd_covox_wr_d;
    logic               underrun_q, underrun_d;
    logic               overflow_q, overflow_d;
    logic               half_irq_q, half_irq_d;
    logic               tick, flush, clr, cpu_busy;
    logic               fifo_pop, issue_fire, set_underrun;
    logic [7:0]         fifo_rd_data;
    logic [FIFO_AW:0]   fifo_level_next;
    logic               fifo_push_drop;

    sound_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_wr),
        .pop        (fifo_pop),
        .flush      (flush),
        .wr_data    (din),
        .rd_data    (fifo_rd_data),
        .level      (fifo_level),
        .level_next (fifo_level_next),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .push_drop  (fifo_push_drop)
    );

    // Register writes and the playback-rate divider; a zero reload behaves as 1.
    always_comb begin
        flush      = ctrl_wr & din[CTRL_FLUSH];
        clr        = ctrl_wr & din[CTRL_CLR];
        cpu_busy   = cpu_beep_wr | cpu_covox_wr;
        play_d     = ctrl_wr ? din[CTRL_PLAY] : play_q;
        rate_d     = rate_q;
        if (rate_wr_lo) rate_d[7:0]       = din;
        if (rate_wr_hi) rate_d[DIV_W-1:8] = din[DIV_W-9:0];
        reload_eff = (rate_q == '0) ? ONE : rate_q;
        tick       = (state_q != ST_IDLE) && (div_q == '0);
        if (state_q == ST_IDLE || tick) div_d = reload_eff;
        else                            div_d = div_q - 1'b1;
    end

    // The hold register parks a CPU covox write that collided with a beeper write.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (cpu_beep_wr) begin
            if (cpu_covox_wr && !hold_valid_q) begin
                hold_valid_d = 1'b1;
                hold_data_d  = din;
            end
        end else if (hold_valid_q) begin
            if (cpu_covox_wr) hold_data_d  = din;
            else              hold_valid_d = 1'b0;
        end
    end

    // A sample only pops in ISSUE when nothing from the CPU claims the port that cycle.
    always_comb begin
        state_d      = state_q;
        fifo_pop     = 1'b0;
        issue_fire   = 1'b0;
        set_underrun = 1'b0;
        if (!play_q) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN: begin
                    if (tick) begin
                        if (fifo_empty)                    set_underrun = 1'b1;
                        else if (cpu_busy || hold_valid_d) state_d = ST_PEND;
                        else                               state_d = ST_ISSUE;
                    end
                end
                ST_PEND: begin
                    if (tick) set_underrun = 1'b1;
                    if (!(cpu_busy || hold_valid_d)) state_d = ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (cpu_busy || hold_valid_q) begin
                        state_d = ST_PEND;
                        if (tick) set_underrun = 1'b1;
                    end else if (fifo_empty || flush) begin
                        set_underrun = 1'b1;
                        state_d      = ST_RUN;
                    end else begin
                        fifo_pop   = 1'b1;
                        issue_fire = 1'b1;
                        state_d    = tick ? ST_PEND : ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        snd_din_d       = snd_din_q;
        snd_beeper_wr_d = 1'b0;
        snd_covox_wr_d  = 1'b0;
        if (cpu_beep_wr) begin
            snd_beeper_wr_d = 1'b1;
            snd_din_d       = din;
        end else if (hold_valid_q) begin
            snd_covox_wr_d = 1'b1;
            snd_din_d      = hold_data_q;
        end else if (cpu_covox_wr) begin
            snd_covox_wr_d = 1'b1;
            snd_din_d      = din;
        end else if (issue_fire) begin
            snd_covox_wr_d = 1'b1;
            snd_din_d      = fifo_rd_data;
        end
        underrun_d = (underrun_q & ~clr) | set_underrun;
        overflow_d = (overflow_q & ~clr) | fifo_push_drop;
        half_irq_d = play_d & (fifo_level_next <= HALF_LVL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            play_q          <= 1'b0;
            rate_q          <= '0;
            div_q           <= '0;
            hold_valid_q    <= 1'b0;
            hold_data_q     <= '0;
            snd_din_q       <= '0;
            snd_beeper_wr_q <= 1'b0;
            snd_covox_wr_q  <= 1'b0;
            underrun_q      <= 1'b0;
            overflow_q      <= 1'b0;
            half_irq_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            play_q          <= play_d;
            rate_q          <= rate_d;
            div_q           <= div_d;
            hold_valid_q    <= hold_valid_d;
            hold_data_q     <= hold_data_d;
            snd_din_q       <= snd_din_d;
            snd_beeper_wr_q <= snd_beeper_wr_d;
            snd_covox_wr_q  <= snd_covox_wr_d;
            underrun_q      <= underrun_d;
            overflow_q      <= overflow_d;
            half_irq_q      <= half_irq_d;
        end
    end

    assign snd_din       = snd_din_q;
    assign snd_beeper_wr = snd_beeper_wr_q;
    assign snd_covox_wr  = snd_covox_wr_q;
    assign underrun      = underrun_q;
    assign overflow      = overflow_q;
    assign half_irq      = half_irq_q;

endmodule
